// File: rtl/demux_dest_pipe.sv
// Registered destination demux: routes each word to the lane named by its
// destination field, parks one word when that lane is paused, counts deliveries.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_PASS | ready for a new word; unpaused words go straight to their lane
// ST_HOLD | one word parked for a paused lane; upstream stalled
module demux_dest_pipe #(
   parameter int DATA_W   = 6,
   parameter int DEST_W   = 1,
   parameter int DEST_LSB = 4,
   parameter int CNT_W    = 8
) (
   input  logic                             clk,
   input  logic                             reset_L,
   input  logic [DATA_W-1:0]                data_in,
   input  logic                             valid_in,
   output logic                             ready_out,
   input  logic [(1<<DEST_W)-1:0]           pause,
   input  logic                             cnt_clr,
   output logic [(1<<DEST_W)*DATA_W-1:0]    data_out,
   output logic [(1<<DEST_W)-1:0]           valid_out,
   output logic [(1<<DEST_W)*CNT_W-1:0]     cnt_out
);

   localparam int NDEST = 1 << DEST_W;

   typedef enum logic {
      ST_PASS = 1'b0,
      ST_HOLD = 1'b1
   } state_t;

   state_t                    state_q;
   logic                      ready_q;
   logic [DATA_W-1:0]         hold_data_q;
   logic [DEST_W-1:0]         hold_dest_q;
   logic [NDEST-1:0]          valid_q;
   logic [NDEST*DATA_W-1:0]   data_q;
   logic [CNT_W-1:0]          cnt_q [NDEST];

   logic [DEST_W-1:0]         in_dest;
   logic                      xfer;
   logic                      park;
   logic                      dlv_en;
   logic [DEST_W-1:0]         dlv_dest;
   logic [DATA_W-1:0]         dlv_data;
   logic [NDEST-1:0]          dlv_oh;

   assign in_dest = data_in[DEST_LSB +: DEST_W];
   assign xfer    = valid_in & ready_q & (state_q == ST_PASS);

   // Delivery decision for this edge: either the incoming word or the parked one.
   always_comb begin
      park     = 1'b0;
      dlv_en   = 1'b0;
      dlv_dest = in_dest;
      dlv_data = data_in;
      if (state_q == ST_PASS) begin
         if (xfer) begin
            if (pause[in_dest]) begin
               park = 1'b1;
            end else begin
               dlv_en = 1'b1;
            end
         end
      end else begin
         dlv_dest = hold_dest_q;
         dlv_data = hold_data_q;
         dlv_en   = ~pause[hold_dest_q];
      end
      dlv_oh = '0;
      if (dlv_en) begin
         dlv_oh[dlv_dest] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         state_q     <= ST_PASS;
         ready_q     <= 1'b0;
         hold_data_q <= '0;
         hold_dest_q <= '0;
         valid_q     <= '0;
         data_q      <= '0;
         for (int k = 0; k < NDEST; k++) begin
            cnt_q[k] <= '0;
         end
      end else begin
         valid_q <= dlv_oh;
         data_q  <= '0;
         if (dlv_en) begin
            data_q[int'(dlv_dest)*DATA_W +: DATA_W] <= dlv_data;
         end

         case (state_q)
            ST_PASS: begin
               ready_q <= 1'b1;
               if (park) begin
                  hold_data_q <= data_in;
                  hold_dest_q <= in_dest;
                  state_q     <= ST_HOLD;
                  ready_q     <= 1'b0;
               end
            end
            ST_HOLD: begin
               // No acceptance on the release edge: ready rises only after it.
               if (dlv_en) begin
                  state_q <= ST_PASS;
                  ready_q <= 1'b1;
               end else begin
                  ready_q <= 1'b0;
               end
            end
            default: begin
               state_q <= ST_PASS;
               ready_q <= 1'b0;
            end
         endcase

         // A clear that coincides with a delivery leaves that lane at one.
         for (int k = 0; k < NDEST; k++) begin
            if (cnt_clr) begin
               cnt_q[k] <= CNT_W'(dlv_oh[k]);
            end else if (dlv_oh[k] && (cnt_q[k] != {CNT_W{1'b1}})) begin
               cnt_q[k] <= cnt_q[k] + 1'b1;
            end
         end
      end
   end

   assign ready_out = ready_q;
   assign valid_out = valid_q;
   assign data_out  = data_q;

   for (genvar g = 0; g < NDEST; g++) begin : g_cnt
      assign cnt_out[g*CNT_W +: CNT_W] = cnt_q[g];
   end

endmodule

// File: tb/tb_demux_dest_pipe.sv
// Directed bench for demux_dest_pipe: default, four-lane and narrow-counter builds.
module tb_demux_dest_pipe;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // default build: 2 lanes, 8-bit counters
   logic [5:0]  da = '0;
   logic        va = 1'b0;
   logic        ra;
   logic [1:0]  pa = '0;
   logic        ca = 1'b0;
   logic [11:0] data_a;
   logic [1:0]  valid_a;
   logic [15:0] cnt_a;

   // four lanes
   logic [5:0]  dw = '0;
   logic        vw = 1'b0;
   logic        rw;
   logic [3:0]  pw = '0;
   logic        cw = 1'b0;
   logic [23:0] data_w;
   logic [3:0]  valid_w;
   logic [31:0] cnt_w;

   // 2-bit counters
   logic [5:0]  ds = '0;
   logic        vs = 1'b0;
   logic        rs;
   logic [1:0]  ps = '0;
   logic        cs = 1'b0;
   logic [11:0] data_s;
   logic [1:0]  valid_s;
   logic [3:0]  cnt_s;

   demux_dest_pipe u_a (
      .clk(clk), .reset_L(rst_n), .data_in(da), .valid_in(va), .ready_out(ra),
      .pause(pa), .cnt_clr(ca), .data_out(data_a), .valid_out(valid_a), .cnt_out(cnt_a));

   demux_dest_pipe #(.DATA_W(6), .DEST_W(2), .DEST_LSB(4), .CNT_W(8)) u_w (
      .clk(clk), .reset_L(rst_n), .data_in(dw), .valid_in(vw), .ready_out(rw),
      .pause(pw), .cnt_clr(cw), .data_out(data_w), .valid_out(valid_w), .cnt_out(cnt_w));

   demux_dest_pipe #(.DATA_W(6), .DEST_W(1), .DEST_LSB(4), .CNT_W(2)) u_s (
      .clk(clk), .reset_L(rst_n), .data_in(ds), .valid_in(vs), .ready_out(rs),
      .pause(ps), .cnt_clr(cs), .data_out(data_s), .valid_out(valid_s), .cnt_out(cnt_s));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #3;
      checks++;
      if ({ra, valid_a, data_a, cnt_a} !== 31'd0) begin
         errors++;
         $display("FAIL reset_outputs got ready=%0b valid=%b data=%h cnt=%h want all 0",
                  ra, valid_a, data_a, cnt_a);
      end
      tick();
      checks++;
      if (ra !== 1'b0) begin
         errors++;
         $display("FAIL reset_ready_held got %0b want 0", ra);
      end
      #3 rst_n = 1'b1;
      tick();
      checks++;
      if ({ra, rw, rs} !== 3'b111) begin
         errors++;
         $display("FAIL ready_after_reset got %b want 111", {ra, rw, rs});
      end
   endtask

   task automatic test_basic();
      logic [5:0] words [4] = '{6'b10_0001, 6'b11_0010, 6'b11_0011, 6'b10_0100};
      logic [1:0] lanes [4] = '{2'b01, 2'b10, 2'b10, 2'b01};
      logic [11:0] exp;
      for (int i = 0; i < 4; i++) begin
         da = words[i];
         va = 1'b1;
         tick();
         exp = (lanes[i] == 2'b01) ? {6'd0, words[i]} : {words[i], 6'd0};
         checks++;
         if (valid_a !== lanes[i] || data_a !== exp || ra !== 1'b1) begin
            errors++;
            $display("FAIL basic_word%0d got valid=%b data=%h ready=%0b want valid=%b data=%h ready=1",
                     i, valid_a, data_a, ra, lanes[i], exp);
         end
      end
      va = 1'b0;
      tick();
      checks++;
      if (valid_a !== 2'b00 || data_a !== 12'd0 || cnt_a !== {8'd2, 8'd2}) begin
         errors++;
         $display("FAIL basic_idle got valid=%b data=%h cnt=%h want 00 000 0202", valid_a, data_a, cnt_a);
      end
   endtask

   task automatic test_pause_hold();
      pa = 2'b10;
      da = 6'b11_0010;
      va = 1'b1;
      tick();
      checks++;
      if (valid_a !== 2'b00 || ra !== 1'b0) begin
         errors++;
         $display("FAIL hold_enter got valid=%b ready=%0b want 00 0", valid_a, ra);
      end
      // a lane-0 word offered while stalled must be ignored
      da = 6'b10_1111;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (valid_a !== 2'b00 || ra !== 1'b0) begin
            errors++;
            $display("FAIL hold_wait%0d got valid=%b ready=%0b want 00 0", i, valid_a, ra);
         end
      end
      pa = 2'b00;
      tick();
      checks++;
      if (valid_a !== 2'b10 || data_a !== {6'b11_0010, 6'd0} || ra !== 1'b1 || cnt_a !== {8'd3, 8'd2}) begin
         errors++;
         $display("FAIL hold_release got valid=%b data=%h ready=%0b cnt=%h want 10 c80 1 0302",
                  valid_a, data_a, ra, cnt_a);
      end
      va = 1'b0;
      tick();
      checks++;
      if (valid_a !== 2'b00 || cnt_a !== {8'd3, 8'd2}) begin
         errors++;
         $display("FAIL hold_no_dup got valid=%b cnt=%h want 00 0302", valid_a, cnt_a);
      end
   endtask

   task automatic test_nonblock();
      logic [5:0] words [2] = '{6'b10_0001, 6'b10_0100};
      pa = 2'b10;
      for (int i = 0; i < 2; i++) begin
         da = words[i];
         va = 1'b1;
         tick();
         checks++;
         if (valid_a !== 2'b01 || data_a !== {6'd0, words[i]} || ra !== 1'b1) begin
            errors++;
            $display("FAIL nonblock_word%0d got valid=%b data=%h ready=%0b want 01 %h 1",
                     i, valid_a, data_a, ra, {6'd0, words[i]});
         end
      end
      va = 1'b0;
      pa = 2'b00;
      tick();
      checks++;
      if (cnt_a !== {8'd3, 8'd4}) begin
         errors++;
         $display("FAIL nonblock_cnt got %h want 0304", cnt_a);
      end
   endtask

   task automatic test_wide();
      logic [5:0] words [4] = '{6'b00_0001, 6'b01_0010, 6'b10_0011, 6'b11_0100};
      logic [23:0] exp;
      for (int i = 0; i < 4; i++) begin
         dw = words[i];
         vw = 1'b1;
         tick();
         exp = '0;
         exp[i*6 +: 6] = words[i];
         checks++;
         if (valid_w !== 4'(1 << i) || data_w !== exp) begin
            errors++;
            $display("FAIL wide_lane%0d got valid=%b data=%h want %b %h", i, valid_w, data_w, 4'(1 << i), exp);
         end
      end
      vw = 1'b0;
      tick();
      checks++;
      if (valid_w !== 4'd0 || cnt_w !== {8'd1, 8'd1, 8'd1, 8'd1}) begin
         errors++;
         $display("FAIL wide_cnt got valid=%b cnt=%h want 0 01010101", valid_w, cnt_w);
      end
   endtask

   task automatic test_saturate();
      logic [1:0] exp;
      for (int i = 0; i < 5; i++) begin
         ds = 6'b00_0001 + 6'(i);
         vs = 1'b1;
         tick();
         exp = (i >= 2) ? 2'd3 : 2'(i + 1);
         checks++;
         if (cnt_s !== {2'd0, exp}) begin
            errors++;
            $display("FAIL sat_word%0d got cnt=%b want %b", i, cnt_s, {2'd0, exp});
         end
      end
      cs = 1'b1;
      tick();
      checks++;
      if (cnt_s !== 4'b0001 || valid_s !== 2'b01) begin
         errors++;
         $display("FAIL sat_clr_deliver got cnt=%b valid=%b want 0001 01", cnt_s, valid_s);
      end
      vs = 1'b0;
      tick();
      checks++;
      if (cnt_s !== 4'b0000) begin
         errors++;
         $display("FAIL sat_clr_idle got cnt=%b want 0000", cnt_s);
      end
      cs = 1'b0;
   endtask

   task automatic test_reset_hold();
      pa = 2'b10;
      da = 6'b01_0111;
      va = 1'b1;
      tick();
      va = 1'b0;
      checks++;
      if (ra !== 1'b0 || valid_a !== 2'b00) begin
         errors++;
         $display("FAIL rsthold_enter got ready=%0b valid=%b want 0 00", ra, valid_a);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({ra, valid_a, data_a, cnt_a} !== 31'd0) begin
         errors++;
         $display("FAIL rsthold_async got ready=%0b valid=%b data=%h cnt=%h want all 0",
                  ra, valid_a, data_a, cnt_a);
      end
      pa = 2'b00;
      tick();
      #2 rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (valid_a !== 2'b00 || data_a !== 12'd0 || cnt_a !== 16'd0 || ra !== 1'b1) begin
            errors++;
            $display("FAIL rsthold_after%0d got valid=%b data=%h cnt=%h ready=%0b want 00 000 0000 1",
                     i, valid_a, data_a, cnt_a, ra);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_pause_hold();
      test_nonblock();
      test_wide();
      test_saturate();
      test_reset_hold();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
